i2s_sample_tx: RTL
==================

I2S_SAMPLE_TX -- requirements
Module: i2s_sample_tx

Interface
REQ-001 SHALL have parameter BCLK_HALF_DIV, default 2, clk_12mhz cycles per BCLK half-period (min 2).
REQ-002 SHALL have parameter SAMPLE_W, default 16, sample width in bits (fixed 16 for this revision).
REQ-003 SHALL have port clk_12mhz  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  run request; sampled once per frame.
REQ-006 SHALL have port fifo_empty  input  1  sample FIFO empty flag.
REQ-007 SHALL have port fifo_read_data  input  16  signed sample; valid the cycle after fifo_read_en.
REQ-008 SHALL have port fifo_read_en  output  1  single-cycle FIFO pop strobe.
REQ-009 SHALL have port i2s_bclk  output  1  I2S bit clock.
REQ-010 SHALL have port i2s_lrck  output  1  I2S word select; 0 = left.
REQ-011 SHALL have port i2s_sdata  output  1  I2S serial data, MSB first.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse per missed sample.
REQ-013 SHALL have port led  output  1  high while in RUN.

Function
- REQ-014 SHALL implement FSM states IDLE, PRIME, RUN.
- REQ-015 IDLE: bclk/lrck/sdata held 0; go PRIME when enable=1 and fifo_empty=0, asserting fifo_read_en for one cycle on that transition.
- REQ-016 PRIME: capture fifo_read_data on the following cycle into next_sample, then enter RUN at slot 0 of a frame.
- REQ-017 RUN: frame = 32 slots (0..31), slot = 2*BCLK_HALF_DIV cycles; bclk low for first half of each slot, high for second half.
- REQ-018 i2s_lrck SHALL be 0 for slots 0..15 and 1 for slots 16..31, changing at slot start (bclk falling).
- REQ-019 At start of slot 1, shift register SHALL load {next_sample, next_sample}; one bit shifted out per slot from slot 1 through slot 0 of the next frame (standard I2S one-bit delay).
- REQ-020 i2s_sdata SHALL change only at slot start; mono sample duplicated to left and right.
- REQ-021 At start of slot 30, if fifo_empty=0, fifo_read_en SHALL pulse one cycle and next_sample capture the data the next cycle.
- REQ-022 At start of slot 30, if fifo_empty=1, no read; next_sample SHALL become 0 and underrun SHALL pulse one cycle.
- REQ-023 At most one fifo_read_en per frame; never asserted while fifo_empty=1.
- REQ-024 enable sampled at start of slot 30: if 0, no fetch and no underrun; after slot 0 of the next frame (last LSB shifted out), go IDLE.
- REQ-025 Slot and frame counters SHALL wrap 31->0 with no gap cycles.

Reset
- REQ-026 rst_n low SHALL immediately force IDLE and all outputs to 0, next_sample and shift register to 0, counters to 0, including mid-frame.
- REQ-027 First fifo_read_en after reset release SHALL occur no earlier than the second clk_12mhz edge.

Configuration
- REQ-028 Macro I2S_TX_UNDERRUN_CNT_EN defined: SHALL add output underrun_count (16 bits, reset 0), incremented per underrun pulse and saturating at 16'hFFFF.
- REQ-029 Macro undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
- REQ-030 Package audio_pkg SHALL hold typedef sample_t (logic signed [15:0]), constant FRAME_SLOTS=32, and the FSM state enum.
- REQ-031 Sub-module i2s_bit_timer SHALL generate bclk, slot_start strobe and slot index from BCLK_HALF_DIV.

Verification (BCLK_HALF_DIV=2: slot=4 cycles, frame=128 cycles)
- REQ-032 FIFO preloaded 16'hA55A, enable=1 -> one pop in PRIME; slots 1..16 and 17..31 plus next slot 0 carry 1010010101011010; lrck and bclk periods 128 and 4 cycles.
- REQ-033 FIFO with 16'h8000 then 16'h7FFF -> pop at each slot 30; frame 2 shifts 0111111111111111 on both channels.
- REQ-034 FIFO empties after one sample -> underrun pulse at slot 30 of frame 1; frame 2 all-zero data; count 1 if macro enabled.
- REQ-035 enable dropped mid-frame -> current frame completes, no further pop, IDLE after next slot 0, outputs 0.
- REQ-036 rst_n asserted at slot 20 -> all outputs 0 in the same cycle; after release, restart from IDLE with a fresh prime pop.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types and constants for the I2S sample transmitter.
// Holds the sample type, frame geometry and the transmitter FSM state encoding.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int FRAME_SLOTS = 32;
    localparam int SLOT_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } tx_state_t;

    // Word select is high for the second half of the frame (right channel).
    function automatic logic slot_is_right(input logic [SLOT_W-1:0] slot);
        return (slot >= SLOT_W'(FRAME_SLOTS / 2));
    endfunction

endpackage

// File: rtl/i2s_bit_timer.sv
// Bit/slot timebase for the I2S transmitter.
// While 'run' is high it produces BCLK (low first half of a slot, high second
// half), a strobe marking the edge at which a new slot begins, and the index of
// that slot. Dropping 'run' returns every counter to zero so the next run
// always starts cleanly at slot 0.
module i2s_bit_timer
    import audio_pkg::*;
#(
    parameter int BCLK_HALF_DIV = 2
)
(
    input  logic              clk_12mhz,
    input  logic              rst_n,
    input  logic              run,
    output logic              bclk,
    output logic              slot_start,
    output logic [SLOT_W-1:0] slot_idx
);

    localparam int                PH_W      = $clog2(2 * BCLK_HALF_DIV);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * BCLK_HALF_DIV - 1);
    localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(BCLK_HALF_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_SLOTS - 1);

    logic [PH_W-1:0]   phase_r;
    logic [SLOT_W-1:0] slot_r;
    logic              active_r;
    logic [PH_W-1:0]   phase_inc_s;

    // Decode whether the coming edge opens a new slot, and which slot it is.
    always_comb begin
        phase_inc_s = phase_r + {{(PH_W-1){1'b0}}, 1'b1};
        slot_start  = 1'b0;
        slot_idx    = slot_r;
        if (!run) begin
            slot_start = 1'b0;
            slot_idx   = {SLOT_W{1'b0}};
        end else if (!active_r) begin
            slot_start = 1'b1;
            slot_idx   = {SLOT_W{1'b0}};
        end else if (phase_r == PH_LAST) begin
            slot_start = 1'b1;
            slot_idx   = (slot_r == SLOT_LAST) ? {SLOT_W{1'b0}} : slot_r + {{(SLOT_W-1){1'b0}}, 1'b1};
        end else begin
            slot_start = 1'b0;
            slot_idx   = slot_r;
        end
    end

    // Advance phase/slot counters and the registered bit clock.
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= 1'b0;
            phase_r  <= {PH_W{1'b0}};
            slot_r   <= {SLOT_W{1'b0}};
            bclk     <= 1'b0;
        end else if (!run) begin
            active_r <= 1'b0;
            phase_r  <= {PH_W{1'b0}};
            slot_r   <= {SLOT_W{1'b0}};
            bclk     <= 1'b0;
        end else if (slot_start) begin
            active_r <= 1'b1;
            phase_r  <= {PH_W{1'b0}};
            slot_r   <= slot_idx;
            bclk     <= 1'b0;
        end else begin
            phase_r  <= phase_inc_s;
            bclk     <= (phase_inc_s >= PH_HALF);
        end
    end

endmodule

// File: rtl/i2s_sample_tx.sv
// Mono I2S transmitter: pops signed samples from a FIFO and sends each one on
// both the left and right channel of a 32-slot frame (standard one-bit delay).
// A new sample is fetched at slot 30 of each frame; if the FIFO is empty the
// next frame carries silence and 'underrun' pulses.
// Optional build macro I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun_count output.
module i2s_sample_tx
    import audio_pkg::*;
#(
    parameter int BCLK_HALF_DIV = 2,
    parameter int SAMPLE_W      = 16
)
(
    input  logic                clk_12mhz,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                fifo_empty,
    input  logic [SAMPLE_W-1:0] fifo_read_data,
    output logic                fifo_read_en,
    output logic                i2s_bclk,
    output logic                i2s_lrck,
    output logic                i2s_sdata,
    output logic                underrun,
    output logic                led
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_count
`endif
);

    tx_state_t               state_r;
    sample_t                 next_sample_r;
    logic [2*SAMPLE_W-1:0]   shift_r;
    logic [2*SAMPLE_W-1:0]   load_s;
    logic                    capture_r;
    logic                    stop_pending_r;
    logic                    boot_ready_r;
    logic                    run_s;
    logic                    slot_start_s;
    logic [SLOT_W-1:0]       slot_idx_s;

    assign run_s  = (state_r == RUN);
    assign load_s = {next_sample_r, next_sample_r};

    i2s_bit_timer #(
        .BCLK_HALF_DIV (BCLK_HALF_DIV)
    ) u_bit_timer (
        .clk_12mhz  (clk_12mhz),
        .rst_n      (rst_n),
        .run        (run_s),
        .bclk       (i2s_bclk),
        .slot_start (slot_start_s),
        .slot_idx   (slot_idx_s)
    );

    // Transmit FSM: FIFO handshake, sample staging, serialisation and status outputs.
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            next_sample_r  <= sample_t'(16'h0000);
            shift_r        <= {(2*SAMPLE_W){1'b0}};
            capture_r      <= 1'b0;
            stop_pending_r <= 1'b0;
            boot_ready_r   <= 1'b0;
            fifo_read_en   <= 1'b0;
            i2s_lrck       <= 1'b0;
            i2s_sdata      <= 1'b0;
            underrun       <= 1'b0;
            led            <= 1'b0;
        end else begin
            // Hold off the first pop until one full edge after reset release.
            boot_ready_r <= 1'b1;
            fifo_read_en <= 1'b0;
            underrun     <= 1'b0;
            // Read data is valid the cycle after the pop strobe.
            capture_r    <= fifo_read_en;
            if (capture_r) begin
                next_sample_r <= sample_t'(fifo_read_data);
            end

            case (state_r)
                IDLE: begin
                    i2s_lrck       <= 1'b0;
                    i2s_sdata      <= 1'b0;
                    led            <= 1'b0;
                    shift_r        <= {(2*SAMPLE_W){1'b0}};
                    stop_pending_r <= 1'b0;
                    if (boot_ready_r && enable && !fifo_empty) begin
                        fifo_read_en <= 1'b1;
                        state_r      <= PRIME;
                    end
                end

                PRIME: begin
                    if (capture_r) begin
                        state_r <= RUN;
                        led     <= 1'b1;
                    end
                end

                RUN: begin
                    if (slot_start_s) begin
                        if ((slot_idx_s == 5'd1) && stop_pending_r) begin
                            // Last LSB has gone out in slot 0: shut down cleanly.
                            state_r        <= IDLE;
                            led            <= 1'b0;
                            i2s_lrck       <= 1'b0;
                            i2s_sdata      <= 1'b0;
                            shift_r        <= {(2*SAMPLE_W){1'b0}};
                            stop_pending_r <= 1'b0;
                        end else begin
                            i2s_lrck <= slot_is_right(slot_idx_s);
                            if (slot_idx_s == 5'd1) begin
                                i2s_sdata <= load_s[2*SAMPLE_W-1];
                                shift_r   <= {load_s[2*SAMPLE_W-2:0], 1'b0};
                            end else begin
                                i2s_sdata <= shift_r[2*SAMPLE_W-1];
                                shift_r   <= {shift_r[2*SAMPLE_W-2:0], 1'b0};
                            end
                            if (slot_idx_s == 5'd30) begin
                                if (!enable) begin
                                    stop_pending_r <= 1'b1;
                                end else if (!fifo_empty) begin
                                    fifo_read_en <= 1'b1;
                                end else begin
                                    next_sample_r <= sample_t'(16'h0000);
                                    underrun      <= 1'b1;
                                end
                            end
                        end
                    end
                end

                default: begin
                    state_r <= IDLE;
                    led     <= 1'b0;
                end
            endcase
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Saturating tally of underrun pulses.
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            underrun_count <= 16'h0000;
        end else if (underrun && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'h0001;
        end
    end
`endif

endmodule
